// File: rtl/ita_hwpe_input_splitter.sv
// ita_hwpe_input_splitter: buffers wide stream words in a FIFO and serializes each into narrow slices,
// lowest slice first, optionally dropping slices whose strobe is all-zero.
module ita_hwpe_input_splitter #(
    parameter int unsigned INPUT_DATA_WIDTH  = 64,
    parameter int unsigned OUTPUT_DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH        = 8,
    parameter bit          SKIP_EMPTY        = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           data_i_valid,
    output logic                           data_i_ready,
    input  logic [INPUT_DATA_WIDTH-1:0]    data_i_data,
    input  logic [INPUT_DATA_WIDTH/8-1:0]  data_i_strb,
    output logic                           data_o_valid,
    input  logic                           data_o_ready,
    output logic [OUTPUT_DATA_WIDTH-1:0]   data_o_data,
    output logic [OUTPUT_DATA_WIDTH/8-1:0] data_o_strb,
    output logic                           empty_o
);
    localparam int unsigned SPLIT_FACTOR = INPUT_DATA_WIDTH / OUTPUT_DATA_WIDTH;
    localparam int unsigned IS = INPUT_DATA_WIDTH / 8;
    localparam int unsigned OS = OUTPUT_DATA_WIDTH / 8;
    localparam int unsigned CW = SPLIT_FACTOR > 2 ? $clog2(SPLIT_FACTOR) : 1;
    localparam int unsigned PW = FIFO_DEPTH > 2 ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);

    if (SPLIT_FACTOR < 2 || INPUT_DATA_WIDTH % OUTPUT_DATA_WIDTH != 0 ||
        OUTPUT_DATA_WIDTH % 8 != 0 || FIFO_DEPTH < 2) begin : g_bad_params
        $error("ita_hwpe_input_splitter: invalid width or depth parameters");
    end

    logic [INPUT_DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [IS-1:0]               mem_strb [FIFO_DEPTH];
    logic [PW-1:0]               wr_ptr, rd_ptr;
    logic [NW-1:0]               fill;
    logic [CW-1:0]               cnt;
    logic [OUTPUT_DATA_WIDTH-1:0] head_data;
    logic [OS-1:0]               head_strb;
    logic fifo_empty, fifo_full, push, pop, advance, last, slice_empty;

    assign fifo_empty   = fill == '0;
    assign fifo_full    = fill == NW'(FIFO_DEPTH);
    assign data_i_ready = !fifo_full;
    assign push         = data_i_valid && data_i_ready;
    assign head_data    = mem_data[rd_ptr][cnt*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH];
    assign head_strb    = mem_strb[rd_ptr][cnt*OS +: OS];
    assign slice_empty  = SKIP_EMPTY && head_strb == '0;
    assign data_o_valid = !fifo_empty && !slice_empty;
    assign data_o_data  = fifo_empty ? '0 : head_data;
    assign data_o_strb  = fifo_empty ? '0 : head_strb;
    // Empty slices are skipped in a single bubble cycle regardless of downstream ready.
    assign advance      = (data_o_valid && data_o_ready) || (!fifo_empty && slice_empty);
    assign last         = cnt == CW'(SPLIT_FACTOR - 1);
    assign pop          = advance && last;
    assign empty_o      = fifo_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            cnt    <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            if (advance) cnt <= last ? '0 : cnt + 1'b1;
            fill <= fill + NW'(push) - NW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data[wr_ptr] <= data_i_data;
            mem_strb[wr_ptr] <= data_i_strb;
        end
    end
endmodule

// File: tb/tb_ita_hwpe_input_splitter.sv
// tb_ita_hwpe_input_splitter: directed checks of splitting, backpressure, FIFO full, skipping, clear and reset.
module tb_ita_hwpe_input_splitter;
    logic        clk = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [7:0]  in_strb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic        empty;
    logic        ns_in_ready;
    logic        ns_valid;
    logic [31:0] ns_data;
    logic [3:0]  ns_strb;
    logic        ns_empty;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ita_hwpe_input_splitter u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
        .data_i_valid(in_valid), .data_i_ready(in_ready), .data_i_data(in_data), .data_i_strb(in_strb),
        .data_o_valid(out_valid), .data_o_ready(out_ready), .data_o_data(out_data), .data_o_strb(out_strb),
        .empty_o(empty)
    );

    ita_hwpe_input_splitter #(.SKIP_EMPTY(1'b0)) u_ns (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
        .data_i_valid(in_valid), .data_i_ready(ns_in_ready), .data_i_data(in_data), .data_i_strb(in_strb),
        .data_o_valid(ns_valid), .data_o_ready(out_ready), .data_o_data(ns_data), .data_o_strb(ns_strb),
        .empty_o(ns_empty)
    );

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({out_valid, out_strb, out_data, empty} !== {1'b0, 4'h0, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", {out_valid, out_strb, out_data, empty}, {1'b0, 4'h0, 32'h0, 1'b1});
        end
        rst_ni = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 64'hBBBBBBBB_AAAAAAAA;
        in_strb = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_strb, out_data, empty} !== {1'b1, 4'hF, 32'hAAAAAAAA, 1'b0}) begin
            failures++;
            $display("FAIL basic_lo got=%h exp=%h", {out_valid, out_strb, out_data, empty}, {1'b1, 4'hF, 32'hAAAAAAAA, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_strb, out_data} !== {1'b1, 4'hF, 32'hBBBBBBBB}) begin
            failures++;
            $display("FAIL basic_hi got=%h exp=%h", {out_valid, out_strb, out_data}, {1'b1, 4'hF, 32'hBBBBBBBB});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, empty} !== 2'b01) begin
            failures++;
            $display("FAIL basic_empty got=%b exp=01", {out_valid, empty});
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 64'hBBBBBBBB_AAAAAAAA;
        in_strb = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, out_strb, out_data} !== {1'b1, 4'hF, 32'hAAAAAAAA}) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got=%h exp=%h", i, {out_valid, out_strb, out_data}, {1'b1, 4'hF, 32'hAAAAAAAA});
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        checks++;
        if ({out_valid, out_strb, out_data} !== {1'b1, 4'hF, 32'hAAAAAAAA}) begin
            failures++;
            $display("FAIL bp_release_lo got=%h exp=%h", {out_valid, out_strb, out_data}, {1'b1, 4'hF, 32'hAAAAAAAA});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_strb, out_data} !== {1'b1, 4'hF, 32'hBBBBBBBB}) begin
            failures++;
            $display("FAIL bp_release_hi got=%h exp=%h", {out_valid, out_strb, out_data}, {1'b1, 4'hF, 32'hBBBBBBBB});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, empty} !== 2'b01) begin
            failures++;
            $display("FAIL bp_empty got=%b exp=01", {out_valid, empty});
        end
    endtask

    task automatic test_fifo_full();
        logic [31:0] got[$];
        logic [31:0] exp_v;
        out_ready = 1'b0;
        in_strb = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL full_ready_before_push word=%0d got=%b exp=1", k, in_ready);
            end
            in_valid = 1'b1;
            in_data = 64'(k);
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready_drop got=%b exp=0", in_ready);
        end
        in_data = 64'd8;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL full_hold got=%h exp=%h", {in_ready, out_valid, out_data}, {1'b0, 1'b1, 32'h0});
        end
        out_ready = 1'b1;
        got.push_back(out_data);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_no_early_accept got=%b exp=0", in_ready);
        end
        if (out_valid) got.push_back(out_data);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_accept_after_pop got=%b exp=1", in_ready);
        end
        if (out_valid) got.push_back(out_data);
        @(negedge clk);
        in_valid = 1'b0;
        for (int t = 0; t < 40 && got.size() < 18; t++) begin
            if (out_valid) got.push_back(out_data);
            @(negedge clk);
        end
        checks++;
        if (got.size() != 18) begin
            failures++;
            $display("FAIL full_count got=%0d exp=18", got.size());
        end
        for (int i = 0; i < 18 && i < got.size(); i++) begin
            exp_v = (i % 2 != 0) ? 32'd0 : 32'(i / 2);
            checks++;
            if (got[i] !== exp_v) begin
                failures++;
                $display("FAIL full_order idx=%0d got=%h exp=%h", i, got[i], exp_v);
            end
        end
        checks++;
        if ({out_valid, empty} !== 2'b01) begin
            failures++;
            $display("FAIL full_drained got=%b exp=01", {out_valid, empty});
        end
    endtask

    task automatic test_skip();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 64'hDDDDDDDD_CCCCCCCC;
        in_strb = 8'hF0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, empty} !== 2'b00) begin
            failures++;
            $display("FAIL skip_bubble got=%b exp=00", {out_valid, empty});
        end
        checks++;
        if ({ns_valid, ns_strb, ns_data} !== {1'b1, 4'h0, 32'hCCCCCCCC}) begin
            failures++;
            $display("FAIL noskip_lo got=%h exp=%h", {ns_valid, ns_strb, ns_data}, {1'b1, 4'h0, 32'hCCCCCCCC});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_strb, out_data} !== {1'b1, 4'hF, 32'hDDDDDDDD}) begin
            failures++;
            $display("FAIL skip_hi got=%h exp=%h", {out_valid, out_strb, out_data}, {1'b1, 4'hF, 32'hDDDDDDDD});
        end
        checks++;
        if ({ns_valid, ns_strb, ns_data} !== {1'b1, 4'hF, 32'hDDDDDDDD}) begin
            failures++;
            $display("FAIL noskip_hi got=%h exp=%h", {ns_valid, ns_strb, ns_data}, {1'b1, 4'hF, 32'hDDDDDDDD});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, empty, ns_empty} !== 3'b011) begin
            failures++;
            $display("FAIL skip_done got=%b exp=011", {out_valid, empty, ns_empty});
        end
        in_valid = 1'b1;
        in_data = 64'h12345678_9ABCDEF0;
        in_strb = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, empty, ns_valid, ns_strb} !== {1'b0, 1'b0, 1'b1, 4'h0}) begin
            failures++;
            $display("FAIL skipz_c0 got=%h exp=%h", {out_valid, empty, ns_valid, ns_strb}, {1'b0, 1'b0, 1'b1, 4'h0});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, empty} !== 2'b00) begin
            failures++;
            $display("FAIL skipz_c1 got=%b exp=00", {out_valid, empty});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, empty} !== 2'b01) begin
            failures++;
            $display("FAIL skipz_dropped got=%b exp=01", {out_valid, empty});
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_strb = 8'hFF;
        in_valid = 1'b1;
        in_data = 64'h0000000B_0000000A;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_data} !== {1'b1, 32'hA}) begin
            failures++;
            $display("FAIL b2b_x_lo got=%h exp=%h", {out_valid, out_data}, {1'b1, 32'hA});
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 64'h0000000D_0000000C;
        checks++;
        if ({out_valid, out_data} !== {1'b1, 32'hB}) begin
            failures++;
            $display("FAIL b2b_x_hi got=%h exp=%h", {out_valid, out_data}, {1'b1, 32'hB});
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_data} !== {1'b1, 32'hC}) begin
            failures++;
            $display("FAIL b2b_y_lo got=%h exp=%h", {out_valid, out_data}, {1'b1, 32'hC});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_data} !== {1'b1, 32'hD}) begin
            failures++;
            $display("FAIL b2b_y_hi got=%h exp=%h", {out_valid, out_data}, {1'b1, 32'hD});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, empty} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_empty got=%b exp=01", {out_valid, empty});
        end
    endtask

    task automatic queue_three();
        out_ready = 1'b0;
        in_strb = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data = {32'(16 * k + 1), 32'(16 * k)};
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_restart(input string tag);
        in_valid = 1'b1;
        in_data = 64'h22222222_11111111;
        in_strb = 8'hFF;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_strb, out_data} !== {1'b1, 4'hF, 32'h11111111}) begin
            failures++;
            $display("FAIL %s_restart_lo got=%h exp=%h", tag, {out_valid, out_strb, out_data}, {1'b1, 4'hF, 32'h11111111});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_data} !== {1'b1, 32'h22222222}) begin
            failures++;
            $display("FAIL %s_restart_hi got=%h exp=%h", tag, {out_valid, out_data}, {1'b1, 32'h22222222});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, empty} !== 2'b01) begin
            failures++;
            $display("FAIL %s_restart_empty got=%b exp=01", tag, {out_valid, empty});
        end
    endtask

    task automatic test_clear();
        queue_three();
        checks++;
        if ({out_valid, out_data} !== {1'b1, 32'h1}) begin
            failures++;
            $display("FAIL clr_cnt1 got=%h exp=%h", {out_valid, out_data}, {1'b1, 32'h1});
        end
        clear_i = 1'b1;
        in_valid = 1'b1;
        in_data = 64'hDEADBEEF_DEADBEEF;
        @(negedge clk);
        clear_i = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_strb, out_data, empty} !== {1'b0, 4'h0, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL clr_flush got=%h exp=%h", {out_valid, out_strb, out_data, empty}, {1'b0, 4'h0, 32'h0, 1'b1});
        end
        check_restart("clr");
    endtask

    task automatic test_reset_mid();
        queue_three();
        checks++;
        if ({out_valid, out_data} !== {1'b1, 32'h1}) begin
            failures++;
            $display("FAIL rst_cnt1 got=%h exp=%h", {out_valid, out_data}, {1'b1, 32'h1});
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_strb, out_data, empty} !== {1'b0, 4'h0, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL rst_async got=%h exp=%h", {out_valid, out_strb, out_data, empty}, {1'b0, 4'h0, 32'h0, 1'b1});
        end
        @(negedge clk);
        rst_ni = 1'b1;
        check_restart("rst");
    endtask

    initial begin
        rst_ni = 1'b0;
        clear_i = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_strb = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_fifo_full();
        test_skip();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
